axis_variable_sink: RTL and testbench

AXI4-Stream slave that terminates a value stream and presents the most recently accepted word as a static register output. It is the receive-side counterpart of a change-driven value transmitter: a PL or PS-side producer streams occasional updates, and this block holds the last value for downstream logic. It also flags changes, counts updates and reports staleness. It sits directly on the slave end of the stream, in the same clock domain as the producer.

---
 rtl/axis_variable_sink_if.sv | 11 +
 rtl/axis_variable_sink.sv | 104 ++++++++++
 tb/tb_axis_variable_sink.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_variable_sink_if.sv
// AXI4-Stream data/valid/ready bundle used to reach the variable sink.
interface axis_variable_sink_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_variable_sink.sv
// AXI4-Stream slave that holds the last accepted word as a static register,
// flags value changes, counts updates and reports staleness.
//
// state  | meaning
// EMPTY  | nothing accepted since reset (data_valid 0, stale 0)
// LIVE   | value held and fresh        (data_valid 1, stale 0)
// STALE  | value held, age >= timeout  (data_valid 1, stale 1)
module axis_variable_sink #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int CNTR_WIDTH       = 32
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_aresetn,
  axis_variable_sink_if.slave         s_axis,
  input  logic                        hold,
  input  logic [CNTR_WIDTH-1:0]       timeout_cfg,
  output logic [AXIS_TDATA_WIDTH-1:0] data_out,
  output logic                        data_valid,
  output logic                        data_changed,
  output logic                        stale,
  output logic [CNTR_WIDTH-1:0]       update_count
);

  // Encoding doubles as the {data_valid, stale} output pair.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_LIVE  = 2'b10,
    ST_STALE = 2'b11
  } state_t;

  localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNTR_WIDTH-1:0] CNT_ONE = {{(CNTR_WIDTH-1){1'b0}}, 1'b1};

  state_t                      state_q, state_d;
  logic                        tready_q;
  logic [AXIS_TDATA_WIDTH-1:0] data_q, data_d;
  logic                        changed_q, changed_d;
  logic [CNTR_WIDTH-1:0]       count_q, count_d;
  logic [CNTR_WIDTH-1:0]       age_q, age_d;
  logic [CNTR_WIDTH-1:0]       age_inc;
  logic                        acc;

  assign acc     = s_axis.tvalid & tready_q;
  assign age_inc = (age_q == CNT_MAX) ? age_q : age_q + CNT_ONE;

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q   <= ST_EMPTY;
      tready_q  <= 1'b0;
      data_q    <= '0;
      changed_q <= 1'b0;
      count_q   <= '0;
      age_q     <= '0;
    end else begin
      state_q   <= state_d;
      tready_q  <= ~hold;
      data_q    <= data_d;
      changed_q <= changed_d;
      count_q   <= count_d;
      age_q     <= age_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    changed_d = 1'b0;
    count_d   = count_q;
    age_d     = age_q;

    if (acc) begin
      data_d    = s_axis.tdata;
      changed_d = (state_q == ST_EMPTY) | (s_axis.tdata != data_q);
      count_d   = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
      age_d     = '0;
      state_d   = ST_LIVE;
    end else begin
      unique case (state_q)
        ST_LIVE, ST_STALE: begin
          // Re-evaluated every idle edge so timeout_cfg edits take effect at once.
          if (timeout_cfg == '0) begin
            age_d   = '0;
            state_d = ST_LIVE;
          end else begin
            age_d   = age_inc;
            state_d = (age_inc >= timeout_cfg) ? ST_STALE : ST_LIVE;
          end
        end
        default: begin
          age_d   = '0;
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  assign s_axis.tready = tready_q;
  assign data_out      = data_q;
  assign data_valid    = state_q[1];
  assign stale         = state_q[0];
  assign data_changed  = changed_q;
  assign update_count  = count_q;

endmodule

// File: tb/tb_axis_variable_sink.sv
// Bench for axis_variable_sink: directed vector table, hand sequences for
// staleness, hold, async reset and saturation, then randomized traffic.
module tb_axis_variable_sink;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axis_variable_sink_if #(.DATA_WIDTH(32)) s_axis ();
  axis_variable_sink_if #(.DATA_WIDTH(32)) s_axis4 ();

  logic        v_drv = 1'b0, h_drv = 1'b0;
  logic [31:0] d_drv = '0, t_drv = '0;
  logic        v4 = 1'b0, h4 = 1'b0;
  logic [31:0] d4 = '0;
  logic [3:0]  t4 = '0;

  assign s_axis.tvalid  = v_drv;
  assign s_axis.tdata   = d_drv;
  assign s_axis4.tvalid = v4;
  assign s_axis4.tdata  = d4;

  logic [31:0] data_out, data_out4;
  logic        data_valid, data_changed, stale;
  logic        data_valid4, data_changed4, stale4;
  logic [31:0] update_count;
  logic [3:0]  update_count4;

  axis_variable_sink #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(32)) u_dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (s_axis),
    .hold           (h_drv),
    .timeout_cfg    (t_drv),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .data_changed   (data_changed),
    .stale          (stale),
    .update_count   (update_count)
  );

  axis_variable_sink #(.AXIS_TDATA_WIDTH(32), .CNTR_WIDTH(4)) u_dut4 (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (s_axis4),
    .hold           (h4),
    .timeout_cfg    (t4),
    .data_out       (data_out4),
    .data_valid     (data_valid4),
    .data_changed   (data_changed4),
    .stale          (stale4),
    .update_count   (update_count4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: what the sink should hold, as plain integers.
  localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;
  bit          m_ready, m_valid, m_changed, m_stale;
  logic [31:0] m_data;
  longint      m_count, m_age;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 0; m_valid = 0; m_changed = 0; m_stale = 0;
    m_data = '0; m_count = 0; m_age = 0;
  endtask

  task automatic model_edge();
    bit acc;
    acc = v_drv && m_ready;
    if (acc) begin
      m_changed = !m_valid || (d_drv != m_data);
      m_data    = d_drv;
      m_valid   = 1;
      if (m_count < MAX32) m_count++;
      m_age     = 0;
      m_stale   = 0;
    end else begin
      m_changed = 0;
      if (!m_valid || t_drv == 0) begin
        m_age   = 0;
        m_stale = 0;
      end else begin
        if (m_age < MAX32) m_age++;
        m_stale = (m_age >= longint'(t_drv));
      end
    end
    m_ready = !h_drv;
  endtask

  task automatic model_check();
    chk("tready",       {63'd0, s_axis.tready}, {63'd0, m_ready});
    chk("data_out",     {32'd0, data_out},      {32'd0, m_data});
    chk("data_valid",   {63'd0, data_valid},    {63'd0, m_valid});
    chk("data_changed", {63'd0, data_changed},  {63'd0, m_changed});
    chk("stale",        {63'd0, stale},         {63'd0, m_stale});
    chk("update_count", {32'd0, update_count},  m_count);
  endtask

  task automatic cycle(input bit v, input logic [31:0] d, input bit h, input logic [31:0] t);
    v_drv = v; d_drv = d; h_drv = h; t_drv = t;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          h;
    logic [31:0] e_data;
    bit          e_valid;
    bit          e_chg;
    int          e_cnt;
    bit          e_rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 32'h1234_5678, 1'b0, 32'h0,         1'b0, 1'b0, 0, 1'b1};
    tbl[1]  = '{1'b1, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b1, 1'b1, 1, 1'b1};
    tbl[2]  = '{1'b0, 32'h0,         1'b0, 32'h1234_5678, 1'b1, 1'b0, 1, 1'b1};
    tbl[3]  = '{1'b1, 32'hA,         1'b0, 32'hA,         1'b1, 1'b1, 2, 1'b1};
    tbl[4]  = '{1'b1, 32'hA,         1'b0, 32'hA,         1'b1, 1'b0, 3, 1'b1};
    tbl[5]  = '{1'b1, 32'hB,         1'b0, 32'hB,         1'b1, 1'b1, 4, 1'b1};
    tbl[6]  = '{1'b0, 32'h0,         1'b0, 32'hB,         1'b1, 1'b0, 4, 1'b1};
    tbl[7]  = '{1'b1, 32'h1,         1'b0, 32'h1,         1'b1, 1'b1, 5, 1'b1};
    tbl[8]  = '{1'b1, 32'h2,         1'b1, 32'h2,         1'b1, 1'b1, 6, 1'b0};
    tbl[9]  = '{1'b1, 32'h3,         1'b1, 32'h2,         1'b1, 1'b0, 6, 1'b0};
    tbl[10] = '{1'b1, 32'h3,         1'b0, 32'h2,         1'b1, 1'b0, 6, 1'b1};
    tbl[11] = '{1'b1, 32'h3,         1'b0, 32'h3,         1'b1, 1'b1, 7, 1'b1};
    tbl[12] = '{1'b1, 32'h4,         1'b0, 32'h4,         1'b1, 1'b1, 8, 1'b1};
    tbl[13] = '{1'b0, 32'h0,         1'b0, 32'h4,         1'b1, 1'b0, 8, 1'b1};

    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_tready",  {63'd0, s_axis.tready}, 64'd0);
    chk("rst_data",    {32'd0, data_out},      64'd0);
    chk("rst_valid",   {63'd0, data_valid},    64'd0);
    chk("rst_changed", {63'd0, data_changed},  64'd0);
    chk("rst_stale",   {63'd0, stale},         64'd0);
    chk("rst_count",   {32'd0, update_count},  64'd0);
    #3 rst_n = 1'b1;

    // Directed vectors, timeout disabled
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].h, 32'd0);
      chk($sformatf("tbl%0d_data", i),  {32'd0, data_out},        {32'd0, tbl[i].e_data});
      chk($sformatf("tbl%0d_valid", i), {63'd0, data_valid},      {63'd0, tbl[i].e_valid});
      chk($sformatf("tbl%0d_chg", i),   {63'd0, data_changed},    {63'd0, tbl[i].e_chg});
      chk($sformatf("tbl%0d_cnt", i),   {32'd0, update_count},    64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_rdy", i),   {63'd0, s_axis.tready},   {63'd0, tbl[i].e_rdy});
      chk($sformatf("tbl%0d_stale", i), {63'd0, stale},           64'd0);
    end

    // Staleness with T = 5
    cycle(1, 32'h55, 0, 32'd5);
    for (int i = 1; i <= 4; i++) begin
      cycle(0, 32'h0, 0, 32'd5);
      chk($sformatf("stale_early%0d", i), {63'd0, stale}, 64'd0);
    end
    cycle(0, 32'h0, 0, 32'd5);
    chk("stale_at_T", {63'd0, stale}, 64'd1);
    cycle(1, 32'h55, 0, 32'd5);
    chk("stale_cleared_by_acc", {63'd0, stale}, 64'd0);
    chk("equal_word_no_chg", {63'd0, data_changed}, 64'd0);
    repeat (5) cycle(0, 32'h0, 0, 32'd5);
    chk("stale_again", {63'd0, stale}, 64'd1);
    cycle(0, 32'h0, 0, 32'd100);
    chk("stale_cfg_raised", {63'd0, stale}, 64'd0);
    cycle(0, 32'h0, 0, 32'd2);
    chk("stale_cfg_lowered", {63'd0, stale}, 64'd1);
    cycle(0, 32'h0, 0, 32'd0);
    chk("stale_cfg_zero", {63'd0, stale}, 64'd0);
    begin
      int seen_stale = 0;
      for (int i = 0; i < 1000; i++) begin
        cycle(0, 32'h0, 0, 32'd0);
        if (stale) seen_stale++;
      end
      chk("stale_disabled_1000", 64'(seen_stale), 64'd0);
    end

    // Asynchronous reset mid-stream, then an equal word must still strobe
    cycle(1, 32'h77, 0, 32'd0);
    cycle(1, 32'h77, 0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_tready",  {63'd0, s_axis.tready}, 64'd0);
    chk("async_data",    {32'd0, data_out},      64'd0);
    chk("async_valid",   {63'd0, data_valid},    64'd0);
    chk("async_changed", {63'd0, data_changed},  64'd0);
    chk("async_count",   {32'd0, update_count},  64'd0);
    chk("async_count4",  {60'd0, update_count4}, 64'd0);
    model_reset();
    @(negedge clk);
    #3 rst_n = 1'b1;
    cycle(1, 32'h77, 0, 32'd0);
    chk("post_rst_no_acc", {32'd0, update_count}, 64'd0);
    cycle(1, 32'h77, 0, 32'd0);
    chk("post_rst_chg", {63'd0, data_changed}, 64'd1);
    chk("post_rst_cnt", {32'd0, update_count}, 64'd1);

    // Narrow counters: update_count and age saturate at 15
    v4 = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      d4 = 32'(i);
      cycle(0, 32'h0, 0, 32'd0);
      if (i == 14) chk("sat_cnt14", {60'd0, update_count4}, 64'd14);
      if (i == 15) chk("sat_cnt15", {60'd0, update_count4}, 64'd15);
    end
    chk("sat_cnt20",  {60'd0, update_count4}, 64'd15);
    chk("sat_data20", {32'd0, data_out4},     64'd20);
    v4 = 1'b0;
    t4 = 4'd15;
    for (int j = 1; j <= 40; j++) begin
      cycle(0, 32'h0, 0, 32'd0);
      if (j == 14) chk("sat_stale14", {63'd0, stale4}, 64'd0);
      if (j == 15) chk("sat_stale15", {63'd0, stale4}, 64'd1);
    end
    chk("sat_stale40", {63'd0, stale4}, 64'd1);
    chk("sat_cnt_idle", {60'd0, update_count4}, 64'd15);

    // Randomized traffic against the reference model
    for (int blk = 0; blk < 15; blk++) begin
      int vp;
      logic [31:0] tc;
      case (blk % 3)
        0: vp = 80;
        1: vp = 20;
        default: vp = 4;
      endcase
      case ($urandom_range(0, 3))
        0: tc = 32'd0;
        1: tc = 32'd1;
        2: tc = 32'd4;
        default: tc = 32'd9;
      endcase
      for (int i = 0; i < 200; i++) begin
        bit v, h;
        v = ($urandom_range(0, 99) < vp);
        h = ($urandom_range(0, 4) == 0);
        if ($urandom_range(0, 49) == 0) tc = 32'($urandom_range(0, 12));
        cycle(v, 32'($urandom_range(0, 3)), h, tc);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
